fifo_ctrl: RTL and testbench

Pointer and flag controller for the FIFO storage array (`memoria`). It turns upstream `push`/`pop` requests into the memory's `wr_enable`, `rd_enable`, `wr_ptr` and `rd_ptr`, and keeps the occupancy count. It also produces full, empty, almost-full and almost-empty flags for the producer and consumer. It sits directly upstream of the memory and shares its clock.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/ptr_counter.sv | 28 ++
 rtl/fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_fifo_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths and reset constants for the FIFO controller and
// the memoria storage array. Both import this package so their default
// geometry always agrees.
package fifo_pkg;

  localparam int DATA_WIDTH    = 10;
  localparam int ADDRESS_WIDTH = 8;
  localparam int DEPTH         = 2 ** ADDRESS_WIDTH;

  // Flag values forced while reset is asserted (empty FIFO).
  localparam logic FULL_RST         = 1'b0;
  localparam logic EMPTY_RST        = 1'b1;
  localparam logic ALMOST_FULL_RST  = 1'b0;
  localparam logic ALMOST_EMPTY_RST = 1'b1;
  localparam logic ERR_RST          = 1'b0;

endpackage : fifo_pkg

// File: rtl/ptr_counter.sv
// ptr_counter: wrap-around address counter with increment enable.
// Wraps from 2**width-1 to 0 by natural binary overflow.
module ptr_counter #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [width-1:0] ptr
);

  logic [width-1:0] ptr_q;
  logic [width-1:0] ptr_d;

  // Next pointer: advance by one when the access was accepted.
  always_comb begin
    ptr_d = ptr_q + {{(width-1){1'b0}}, inc};
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule : ptr_counter

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller for the memoria array.
// Optional macro FIFO_CTRL_ERR_EN enables sticky overflow/underflow flags;
// without it both error ports are tied low.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH,
  parameter int address_width = ADDRESS_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [address_width:0] almost_full_th,
  input  logic [address_width:0] almost_empty_th,
  output logic                   wr_enable,
  output logic                   rd_enable,
  output logic [address_width-1:0] wr_ptr,
  output logic [address_width-1:0] rd_ptr,
  output logic [address_width:0] fifo_count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow_err,
  output logic                   underflow_err
);

  localparam logic [address_width:0] CNT_ONE   = {{address_width{1'b0}}, 1'b1};
  localparam logic [address_width:0] CNT_DEPTH = {1'b1, {address_width{1'b0}}};

  logic [address_width:0] count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic almost_full_q, almost_full_d;
  logic almost_empty_q, almost_empty_d;

  // Strobes: accept push unless full, pop unless empty. Held low while in
  // reset so the memory never sees a write during reset.
  always_comb begin
    wr_enable = push & ~full_q & reset;
    rd_enable = pop & ~empty_q & reset;
  end

  ptr_counter #(.width(address_width)) u_wr_ptr (
    .clk   (clk),
    .rst_n (reset),
    .inc   (wr_enable),
    .ptr   (wr_ptr)
  );

  ptr_counter #(.width(address_width)) u_rd_ptr (
    .clk   (clk),
    .rst_n (reset),
    .inc   (rd_enable),
    .ptr   (rd_ptr)
  );

  // Next occupancy and flags; flags come from the next count so they always
  // agree with fifo_count in the same cycle.
  always_comb begin
    count_d = count_q;
    case ({wr_enable, rd_enable})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d         = (count_d == CNT_DEPTH);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= almost_full_th);
    almost_empty_d = (count_d <= almost_empty_th);
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q        <= '0;
      full_q         <= FULL_RST;
      empty_q        <= EMPTY_RST;
      almost_full_q  <= ALMOST_FULL_RST;
      almost_empty_q <= ALMOST_EMPTY_RST;
    end else begin
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign fifo_count   = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error capture: rejected push while full / pop while empty.
  always_comb begin
    overflow_d  = overflow_q | (push & full_q);
    underflow_d = underflow_q | (pop & empty_q);
  end

  // Error registers, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= ERR_RST;
      underflow_q <= ERR_RST;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed test of fifo_ctrl, one task per scenario.
module tb_fifo_ctrl;

  localparam int AW = 8;
`ifdef FIFO_CTRL_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          push, pop;
  logic [AW:0]   almost_full_th, almost_empty_th;
  logic          wr_enable, rd_enable;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic          full, empty, almost_full, almost_empty;
  logic          overflow_err, underflow_err;

  int vectors = 0;
  int errors  = 0;

  fifo_ctrl #(.data_width(10), .address_width(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .pop             (pop),
    .almost_full_th  (almost_full_th),
    .almost_empty_th (almost_empty_th),
    .wr_enable       (wr_enable),
    .rd_enable       (rd_enable),
    .wr_ptr          (wr_ptr),
    .rd_ptr          (rd_ptr),
    .fifo_count      (fifo_count),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .overflow_err    (overflow_err),
    .underflow_err   (underflow_err)
  );

  always #5 clk = ~clk;

  // Apply one clock edge with the current inputs, then settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 1'b0;
    pop  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    push  = 1'b1;
    pop   = 1'b1;
    tick();
    tick();
    vectors++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", wr_enable); end
    vectors++; if (rd_enable !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b want 0", rd_enable); end
    vectors++; if (wr_ptr !== 8'd0 || rd_ptr !== 8'd0) begin errors++; $display("FAIL rst_ptrs: got %0d/%0d want 0/0", wr_ptr, rd_ptr); end
    vectors++; if (fifo_count !== 9'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    vectors++; if ({empty, full, almost_full, almost_empty} !== 4'b1001) begin errors++; $display("FAIL rst_flags: got %b want 1001", {empty, full, almost_full, almost_empty}); end
    vectors++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b want 00", {overflow_err, underflow_err}); end
    push = 1'b0;
    pop  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    push = 1'b1;
    #1;
    vectors++; if (wr_enable !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b want 1", wr_enable); end
    tick();
    push = 1'b0;
    vectors++; if (wr_ptr !== 8'd1 || fifo_count !== 9'd1) begin errors++; $display("FAIL single_push: ptr %0d cnt %0d want 1/1", wr_ptr, fifo_count); end
    vectors++; if ({empty, almost_empty} !== 2'b01) begin errors++; $display("FAIL single_push_flags: got %b want 01", {empty, almost_empty}); end
    pop = 1'b1;
    #1;
    vectors++; if (rd_enable !== 1'b1) begin errors++; $display("FAIL single_rd_en: got %b want 1", rd_enable); end
    tick();
    pop = 1'b0;
    vectors++; if (rd_ptr !== 8'd1 || fifo_count !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_pop: ptr %0d cnt %0d empty %b want 1/0/1", rd_ptr, fifo_count, empty); end
  endtask

  task automatic test_fill();
    do_reset();
    almost_full_th = 9'd250;
    push = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 249) begin
        vectors++; if (almost_full !== 1'b0) begin errors++; $display("FAIL fill_af_249: got %b want 0", almost_full); end
      end
      if (i == 250) begin
        vectors++; if (almost_full !== 1'b1 || fifo_count !== 9'd250) begin errors++; $display("FAIL fill_af_250: af %b cnt %0d want 1/250", almost_full, fifo_count); end
      end
      if (i == 255) begin
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_255: got %b want 0", full); end
      end
    end
    vectors++; if (full !== 1'b1 || fifo_count !== 9'd256 || wr_ptr !== 8'd0) begin errors++; $display("FAIL fill_full: full %b cnt %0d ptr %0d want 1/256/0", full, fifo_count, wr_ptr); end
    vectors++; if (almost_empty !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL fill_ae: ae %b empty %b want 0/0", almost_empty, empty); end
    // 257th push is rejected
    vectors++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL ovf_wr_en: got %b want 0", wr_enable); end
    tick();
    push = 1'b0;
    vectors++; if (fifo_count !== 9'd256 || wr_ptr !== 8'd0) begin errors++; $display("FAIL ovf_hold: cnt %0d ptr %0d want 256/0", fifo_count, wr_ptr); end
    vectors++; if (overflow_err !== ERR_EXP || underflow_err !== 1'b0) begin errors++; $display("FAIL ovf_err: got %b%b want %b0", overflow_err, underflow_err, ERR_EXP); end
  endtask

  task automatic test_back_to_back();
    // both while full: only the pop goes through
    push = 1'b1;
    pop  = 1'b1;
    #1;
    vectors++; if ({wr_enable, rd_enable} !== 2'b01) begin errors++; $display("FAIL bb_full_strobes: got %b want 01", {wr_enable, rd_enable}); end
    tick();
    push = 1'b0;
    pop  = 1'b0;
    vectors++; if (fifo_count !== 9'd255 || full !== 1'b0 || rd_ptr !== 8'd1 || wr_ptr !== 8'd0) begin errors++; $display("FAIL bb_full: cnt %0d full %b rd %0d wr %0d want 255/0/1/0", fifo_count, full, rd_ptr, wr_ptr); end
    // both at count 100
    do_reset();
    push = 1'b1;
    repeat (100) tick();
    pop = 1'b1;
    tick();
    push = 1'b0;
    pop  = 1'b0;
    vectors++; if (fifo_count !== 9'd100 || wr_ptr !== 8'd101 || rd_ptr !== 8'd1) begin errors++; $display("FAIL bb_mid: cnt %0d wr %0d rd %0d want 100/101/1", fifo_count, wr_ptr, rd_ptr); end
    // both while empty: only the push goes through
    do_reset();
    push = 1'b1;
    pop  = 1'b1;
    #1;
    vectors++; if ({wr_enable, rd_enable} !== 2'b10) begin errors++; $display("FAIL bb_empty_strobes: got %b want 10", {wr_enable, rd_enable}); end
    tick();
    push = 1'b0;
    pop  = 1'b0;
    vectors++; if (fifo_count !== 9'd1 || empty !== 1'b0 || wr_ptr !== 8'd1 || rd_ptr !== 8'd0) begin errors++; $display("FAIL bb_empty: cnt %0d empty %b wr %0d rd %0d want 1/0/1/0", fifo_count, empty, wr_ptr, rd_ptr); end
  endtask

  task automatic test_underflow();
    do_reset();
    pop = 1'b1;
    #1;
    vectors++; if (rd_enable !== 1'b0) begin errors++; $display("FAIL unf_rd_en: got %b want 0", rd_enable); end
    tick();
    pop = 1'b0;
    vectors++; if (rd_ptr !== 8'd0 || fifo_count !== 9'd0 || empty !== 1'b1) begin errors++; $display("FAIL unf_hold: rd %0d cnt %0d empty %b want 0/0/1", rd_ptr, fifo_count, empty); end
    vectors++; if (underflow_err !== ERR_EXP || overflow_err !== 1'b0) begin errors++; $display("FAIL unf_err: got %b%b want 0%b", overflow_err, underflow_err, ERR_EXP); end
    // almost_empty threshold boundary: th 0, count 1 -> deasserted
    almost_empty_th = 9'd0;
    push = 1'b1;
    tick();
    push = 1'b0;
    vectors++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL ae_th0: got %b want 0", almost_empty); end
    almost_empty_th = 9'd1;
    tick();
    vectors++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL ae_th1: got %b want 1", almost_empty); end
    almost_empty_th = 9'd4;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push = 1'b1;
    repeat (37) tick();
    push = 1'b0;
    vectors++; if (fifo_count !== 9'd37 || wr_ptr !== 8'd37) begin errors++; $display("FAIL mid_pre: cnt %0d ptr %0d want 37/37", fifo_count, wr_ptr); end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (fifo_count !== 9'd0 || wr_ptr !== 8'd0 || rd_ptr !== 8'd0) begin errors++; $display("FAIL mid_state: cnt %0d wr %0d rd %0d want 0/0/0", fifo_count, wr_ptr, rd_ptr); end
    vectors++; if ({empty, full, almost_full, almost_empty} !== 4'b1001) begin errors++; $display("FAIL mid_flags: got %b want 1001", {empty, full, almost_full, almost_empty}); end
    vectors++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("FAIL mid_errs: got %b want 00", {overflow_err, underflow_err}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset           = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    almost_full_th  = 9'd250;
    almost_empty_th = 9'd4;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_fifo_ctrl
